// File: rtl/hsv_ctrl_pkg.sv
// Shared types and constants for the HSV stream controller: FSM states,
// the tag carried alongside the external converter, and the buffered word.
package hsv_ctrl_pkg;

    localparam int DATA_W = 24;
    localparam int TYPE_W = 4;
    localparam int FCNT_W = 16;

    localparam logic [TYPE_W-1:0] PKT_VIDEO = 4'h0;

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        VIDEO    = 2'd1,
        PASS     = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] raw_data;
        logic              sop;
        logic              eop;
        logic              convert;
    } tag_t;

    // video_eop marks the last word of a converted packet so the frame
    // counter can step when that word leaves the buffer.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              video_eop;
    } out_word_t;

    localparam int OUT_W = $bits(out_word_t);

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A write is still taken when full provided a read happens the same cycle.
module stream_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full, do_wr, do_rd;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        do_rd    = rd_en & ~empty;
        do_wr    = wr_en & (~full | do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hsv_stream_ctrl.sv
// Packet-aware wrapper around an external fixed-latency RGB-to-HSV datapath:
// classifies packets, tags words through the converter latency, and buffers output.
module hsv_stream_ctrl
    import hsv_ctrl_pkg::*;
#(
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_valid,
    input  logic              sink_sop,
    input  logic              sink_eop,
    output logic              sink_ready,
    output logic [DATA_W-1:0] source_data,
    output logic              source_valid,
    output logic              source_sop,
    output logic              source_eop,
    input  logic              source_ready,
    output logic [DATA_W-1:0] conv_in_data,
    output logic              conv_in_en,
    input  logic [DATA_W-1:0] conv_out_data,
    input  logic              cfg_enable,
    output logic [FCNT_W-1:0] frame_count,
    output logic              busy
);

    localparam int CW    = $clog2(FIFO_DEPTH);
    localparam int OCC_W = CW + 2;

    state_e              state_q, state_d;
    logic [PIPE_LAT-1:0] vld_pipe_q, vld_pipe_d;
    tag_t                tag_q [PIPE_LAT];
    tag_t                tag_d [PIPE_LAT];
    logic                rdy_en_q, rdy_en_d;
    logic [FCNT_W-1:0]   frame_count_q, frame_count_d;

    logic                accept, keep, convert;
    logic [OCC_W-1:0]    inflight, outstanding;
    logic                fifo_wr, fifo_rd, fifo_empty;
    logic [CW:0]         fifo_count;
    out_word_t           fifo_wdata, head;
    tag_t                tail;

    // Input classification and next-state
    always_comb begin
        accept  = sink_valid & sink_ready;
        keep    = 1'b0;
        convert = 1'b0;
        state_d = state_q;
        if (accept) begin
            if (sink_sop) begin
                keep = 1'b1;
                if (sink_eop) begin
                    state_d = WAIT_SOP;
                end else if (sink_data[TYPE_W-1:0] == PKT_VIDEO && cfg_enable) begin
                    state_d = VIDEO;
                end else begin
                    state_d = PASS;
                end
            end else if (state_q != WAIT_SOP) begin
                keep    = 1'b1;
                convert = (state_q == VIDEO);
                if (sink_eop) begin
                    state_d = WAIT_SOP;
                end
            end
        end
    end

    assign conv_in_en   = convert;
    assign conv_in_data = sink_data;

    // Tag pipeline tracks each word through the converter latency
    always_comb begin
        vld_pipe_d[0] = keep;
        tag_d[0]      = '{raw_data: sink_data, sop: sink_sop, eop: sink_eop, convert: convert};
        for (int i = 1; i < PIPE_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_d[i]      = tag_q[i-1];
        end
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + OCC_W'(vld_pipe_q[i]);
        end
    end

    always_comb begin
        tail       = tag_q[PIPE_LAT-1];
        fifo_wr    = vld_pipe_q[PIPE_LAT-1];
        fifo_wdata = '{data:      tail.convert ? conv_out_data : tail.raw_data,
                       sop:       tail.sop,
                       eop:       tail.eop,
                       video_eop: tail.convert & tail.eop};
    end

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Credit counts words in the converter too, so the FIFO can never overflow
    // and sink_ready is independent of source_ready.
    always_comb begin
        outstanding   = OCC_W'(fifo_count) + inflight;
        sink_ready    = rdy_en_q & ~reset & (outstanding < OCC_W'(FIFO_DEPTH));
        source_valid  = ~reset & ~fifo_empty;
        fifo_rd       = source_valid & source_ready;
        rdy_en_d      = 1'b1;
        frame_count_d = frame_count_q;
        if (fifo_rd && head.video_eop) begin
            frame_count_d = frame_count_q + FCNT_W'(1);
        end
    end

    assign source_data = head.data;
    assign source_sop  = head.sop;
    assign source_eop  = head.eop;
    assign frame_count = frame_count_q;
    assign busy        = ~reset & ((state_q != WAIT_SOP) | (|vld_pipe_q) | ~fifo_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_SOP;
            vld_pipe_q    <= '0;
            rdy_en_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            vld_pipe_q    <= vld_pipe_d;
            rdy_en_q      <= rdy_en_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PIPE_LAT; i++) begin
            tag_q[i] <= tag_d[i];
        end
    end

endmodule

// File: tb/tb_hsv_stream_ctrl.sv
// Randomised scoreboard bench for hsv_stream_ctrl with a behavioural
// RGB-to-HSV converter attached to the converter port.
module tb_hsv_stream_ctrl;

    localparam int PL = 3;
    localparam int FD = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] sink_data = '0;
    logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
    logic        sink_ready;
    logic [23:0] source_data;
    logic        source_valid, source_sop, source_eop;
    logic        source_ready = 1'b1;
    logic [23:0] conv_in_data, conv_out_data;
    logic        conv_in_en;
    logic        cfg_enable = 1'b1;
    logic [15:0] frame_count;
    logic        busy;

    always #5 clk = ~clk;

    hsv_stream_ctrl #(.PIPE_LAT(PL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid),
        .source_sop(source_sop), .source_eop(source_eop), .source_ready(source_ready),
        .conv_in_data(conv_in_data), .conv_in_en(conv_in_en), .conv_out_data(conv_out_data),
        .cfg_enable(cfg_enable), .frame_count(frame_count), .busy(busy)
    );

    // Hue in half-degrees (0..179), saturation and value in 0..255.
    function automatic logic [23:0] rgb2hsv(input logic [23:0] rgb);
        int r, g, b, mx, mn, d, h, s;
        r = int'(rgb[23:16]); g = int'(rgb[15:8]); b = int'(rgb[7:0]);
        mx = (r > g) ? r : g; mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g; mn = (mn < b) ? mn : b;
        d  = mx - mn;
        s  = (mx == 0) ? 0 : (255 * d) / mx;
        if (d == 0)       h = 0;
        else if (mx == r) h = (30 * (g - b)) / d;
        else if (mx == g) h = 60 + (30 * (b - r)) / d;
        else              h = 120 + (30 * (r - g)) / d;
        if (h < 0) h = h + 180;
        return {h[7:0], s[7:0], mx[7:0]};
    endfunction

    // External converter: exactly PL cycles, garbage when not enabled
    logic [23:0] cpipe [PL];
    always @(posedge clk) begin
        cpipe[0] <= conv_in_en ? conv_in_data : 24'($urandom);
        for (int i = 1; i < PL; i++) cpipe[i] <= cpipe[i-1];
    end
    assign conv_out_data = rgb2hsv(cpipe[PL-1]);

    typedef struct packed {
        logic [23:0] d;
        logic        sop;
        logic        eop;
        logic        veop;
    } exp_t;

    exp_t        sbq [$];
    logic [23:0] out_log [$];
    int checks = 0, fails = 0;
    int mode = 0, since = 0, rst_age = 0, exp_frames = 0, conv_seen = 0, saw_full = 0;
    int sr_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (sr_mode)
                0:       source_ready = 1'b1;
                1:       source_ready = 1'b0;
                default: source_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor + reference model, sampled on the falling edge
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [23:0] d;
        bit          cv;
        if (reset) begin
            chk("rst_sink_ready", 32'(sink_ready), 32'(0));
            chk("rst_source_valid", 32'(source_valid), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_conv_in_en", 32'(conv_in_en), 32'(0));
            if (rst_age > 0) chk("rst_frame_count", 32'(frame_count), 32'(0));
            rst_age++;
            since = 0;
            sbq.delete();
            mode = 0;
            exp_frames = 0;
        end else begin
            rst_age = 0;
            since++;
            if (since >= 2) chk("sink_ready_credit", 32'(sink_ready), 32'(sbq.size() < FD));
            if (sbq.size() == FD) saw_full = 1;
            chk("busy", 32'(busy), 32'(mode != 0 || sbq.size() != 0));
            chk("frame_count", 32'(frame_count), 32'(exp_frames & 16'hFFFF));
            if (source_valid && source_ready) begin
                if (sbq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_output: got %h expected none", source_data);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", 32'(source_data), 32'(e.d));
                    chk("out_sop", 32'(source_sop), 32'(e.sop));
                    chk("out_eop", 32'(source_eop), 32'(e.eop));
                    out_log.push_back(source_data);
                    if (e.veop) exp_frames++;
                end
            end
            if (sink_valid && sink_ready) begin
                d  = sink_data;
                cv = 1'b0;
                if (sink_sop) begin
                    sbq.push_back('{d: d, sop: 1'b1, eop: sink_eop, veop: 1'b0});
                    if (sink_eop) mode = 0;
                    else if (d[3:0] == 4'h0 && cfg_enable) mode = 1;
                    else mode = 2;
                end else if (mode != 0) begin
                    cv = (mode == 1);
                    sbq.push_back('{d: cv ? rgb2hsv(d) : d, sop: 1'b0, eop: sink_eop,
                                    veop: cv && sink_eop});
                    if (sink_eop) mode = 0;
                end
                chk("conv_in_en", 32'(conv_in_en), 32'(cv));
                if (cv) begin
                    chk("conv_in_data", 32'(conv_in_data), 32'(d));
                    conv_seen++;
                end
            end else begin
                chk("conv_idle", 32'(conv_in_en), 32'(0));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [23:0] d, input logic sop, input logic eop);
        int   n = 0;
        logic acc;
        sink_data = d; sink_sop = sop; sink_eop = eop; sink_valid = 1'b1;
        do begin
            @(negedge clk); acc = sink_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 3000);
        sink_valid = 1'b0;
        if (!acc) begin
            checks++; fails++;
            $display("FAIL send_timeout: word %h not accepted", d);
        end
    endtask

    task automatic packet(input logic [3:0] typ, input int len, input bit toggle, input bit gaps);
        send({20'($urandom), typ}, 1'b1, len == 0);
        for (int i = 0; i < len; i++) begin
            if (toggle) cfg_enable = 1'($urandom_range(0, 1));
            send(24'($urandom), 1'b0, i == len - 1);
            if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || source_valid) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        idle(2);
        chk("drain_empty", 32'(sbq.size()), 32'(0));
    endtask

    initial begin
        int c0;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Video packet with known conversion results
        send(24'h000000, 1'b1, 1'b0);
        send(24'hC8193C, 1'b0, 1'b0);
        send(24'h010203, 1'b0, 1'b1);
        drain();
        chk("vid_outputs", 32'(out_log.size()), 32'(3));
        chk("vid_hdr", 32'(out_log[0]), 32'h000000);
        chk("vid_px0", 32'(out_log[1]), 32'hAEDFC8);
        chk("vid_px1", 32'(out_log[2]), 32'h69AA03);
        chk("vid_frames", 32'(frame_count), 32'(1));

        // Control packet passes bit-identical
        c0 = conv_seen;
        send(24'h00000F, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, i == 2);
        drain();
        chk("ctrl_no_conv", 32'(conv_seen), 32'(c0));
        chk("ctrl_frames", 32'(frame_count), 32'(1));

        // cfg_enable sampled only on header
        cfg_enable = 1'b0;
        send(24'h000000, 1'b1, 1'b0);
        cfg_enable = 1'b1;
        for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, i == 2);
        drain();
        chk("cfg_off_no_conv", 32'(conv_seen), 32'(c0));
        packet(4'h0, 5, 1'b1, 1'b0);
        cfg_enable = 1'b1;
        drain();
        chk("cfg_toggle_conv", 32'(conv_seen), 32'(c0 + 5));
        chk("cfg_frames", 32'(frame_count), 32'(2));

        // Words before any sop are dropped
        for (int i = 0; i < 5; i++) send(24'($urandom), 1'b0, i == 4);
        packet(4'h0, 4, 1'b0, 1'b0);
        drain();
        chk("drop_frames", 32'(frame_count), 32'(3));

        // Backpressure with a 64-pixel packet
        sr_mode = 1;
        fork
            packet(4'h0, 64, 1'b0, 1'b0);
            begin
                idle(60);
                chk("backpressure_full", 32'(saw_full), 32'(1));
                chk("backpressure_stall", 32'(sink_ready), 32'(0));
                sr_mode = 2;
            end
        join
        drain();
        chk("bp_frames", 32'(frame_count), 32'(4));

        // Header-only packet, then sop inside open packets
        sr_mode = 0;
        send(24'h000000, 1'b1, 1'b1);
        send(24'h123456, 1'b0, 1'b0);
        send(24'h000000, 1'b1, 1'b0);
        send(24'h405060, 1'b0, 1'b0);
        send(24'h000003, 1'b1, 1'b0);
        send(24'h708090, 1'b0, 1'b0);
        send(24'h0A0B0C, 1'b0, 1'b1);
        drain();
        chk("resop_frames", 32'(frame_count), 32'(4));

        // Reset pulse with 10 words buffered
        sr_mode = 1;
        send(24'h000000, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) send(24'($urandom), 1'b0, 1'b0);
        idle(PL + 3);
        chk("buffered_10", 32'(sbq.size()), 32'(10));
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        sr_mode = 0;
        @(negedge clk);
        chk("post_rst_valid", 32'(source_valid), 32'(0));
        chk("post_rst_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        packet(4'h0, 6, 1'b0, 1'b0);
        drain();
        chk("post_rst_frames", 32'(frame_count), 32'(1));

        // Randomised traffic
        sr_mode = 2;
        for (int p = 0; p < 25; p++) begin
            logic [3:0] typ;
            cfg_enable = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) send(24'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 3))
                0, 1:    typ = 4'h0;
                2:       typ = 4'h1;
                default: typ = 4'hF;
            endcase
            packet(typ, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();
        chk("rand_frames", 32'(frame_count), 32'(exp_frames));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hsv_stream_ctrl.md
HSV_STREAM_CTRL -- requirements
Module: hsv_stream_ctrl

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 3: fixed latency, in cycles, of the external RGB-to-HSV datapath, legal range 1..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: output buffer depth in words, power of two, at least PIPE_LAT+2.
REQ-003 clk  in  1  the single clock; all logic is rising-edge.
REQ-004 reset  in  1  synchronous reset, active-high.
REQ-005 sink_data  in  24  input word, {R,G,B} for video pixels.
REQ-006 sink_valid / sink_sop / sink_eop  in  1 each  input word qualifiers.
REQ-007 sink_ready  out  1  block accepts a word this cycle.
REQ-008 source_data  out  24  output word, {H,S,V} for video pixels.
REQ-009 source_valid / source_sop / source_eop  out  1 each  output word qualifiers.
REQ-010 source_ready  in  1  downstream accepts a word this cycle.
REQ-011 conv_in_data  out  24  RGB word driven to the converter.
REQ-012 conv_in_en  out  1  conv_in_data is a pixel to convert.
REQ-013 conv_out_data  in  24  converter result, valid exactly PIPE_LAT cycles after conv_in_en.
REQ-014 cfg_enable  in  1  when 0, all packets pass through unconverted.
REQ-015 frame_count  out  16  number of completed video packets.
REQ-016 busy  out  1  a packet is open, or words are in flight or buffered.

Function
REQ-017 A word is accepted when sink_valid and sink_ready are both 1; output is consumed when source_valid and source_ready are both 1.
REQ-018 FSM states SHALL be WAIT_SOP, VIDEO and PASS.
REQ-019 In WAIT_SOP, accepted words without sop SHALL be dropped.
REQ-020 An accepted sop word SHALL be forwarded unconverted as a header; its sink_data[3:0] is the packet type.
REQ-021 On the header, type 0 with cfg_enable=1 SHALL go to VIDEO; any other combination SHALL go to PASS.
REQ-022 cfg_enable SHALL be sampled only on the header word.
REQ-023 In VIDEO, each accepted non-sop word SHALL drive conv_in_data=sink_data and conv_in_en=1 in the same cycle.
REQ-024 In PASS, words SHALL be forwarded unconverted and conv_in_en SHALL stay 0.
REQ-025 An accepted eop word SHALL return the FSM to WAIT_SOP.
REQ-026 Simultaneous sop and eop on one word (header-only packet) SHALL forward that word and stay in WAIT_SOP.
REQ-027 An sop in VIDEO or PASS SHALL be treated as a new header, with no eop inserted.
REQ-028 Every accepted, non-dropped word SHALL enter a PIPE_LAT-deep tag pipeline carrying {raw_data, sop, eop, convert}.
REQ-029 At the pipeline tail, the buffered word SHALL be conv_out_data when convert=1, else raw_data; sop and eop SHALL be preserved.
REQ-030 Output word order SHALL equal input order.
REQ-031 sink_ready SHALL be 1 only when (FIFO occupancy + words in flight) < FIFO_DEPTH, so the FIFO never overflows.
REQ-032 sink_ready SHALL NOT depend combinationally on source_ready.
REQ-033 source_valid SHALL equal FIFO not-empty; source_data, sop and eop come from the FIFO head.
REQ-034 A FIFO write and read in the same cycle SHALL both occur, including when the FIFO is full or empty at the tail.
REQ-035 Minimum latency from accepted input to source_valid SHALL be PIPE_LAT+1 cycles.
REQ-036 frame_count SHALL increment when a video packet's eop leaves the FIFO, and SHALL wrap from 0xFFFF to 0.

Reset
REQ-037 While reset=1: FSM in WAIT_SOP; tag pipeline and FIFO empty; sink_ready, source_valid, conv_in_en and busy all 0; frame_count 0.
REQ-038 sink_ready SHALL rise no earlier than the first cycle after reset deasserts.
REQ-039 Reset asserted mid-packet SHALL discard all in-flight and buffered words.

Structure
REQ-040 Package hsv_ctrl_pkg SHALL hold the state enum, PKT_VIDEO=4'h0, the tag struct and the width constants.
REQ-041 The output buffer SHALL be a sub-module stream_fifo: a synchronous FIFO with first-word-fall-through, a count output and a DEPTH parameter.

Verification
REQ-042 Video packet {000000 sop, C8193C, 010203 eop} with a real RGB_TO_HSV attached and source_ready=1 -> outputs 000000 sop, AEDFC8, then the converted 010203 with eop; frame_count=1.
REQ-043 Header 00000F (control packet) followed by 3 words -> all 4 words bit-identical on the output, conv_in_en never 1, frame_count unchanged.
REQ-044 cfg_enable=0 at a type-0 header -> packet passes unconverted; cfg_enable toggled mid-packet -> no effect on that packet.
REQ-045 source_ready=0 with a continuous 64-pixel packet -> sink_ready drops once 16 words are outstanding, no word lost or duplicated; random source_ready afterwards -> exact in-order output.
REQ-046 5 words without sop, then a packet -> first 5 dropped, packet delivered intact.
REQ-047 reset pulsed for 1 cycle with 10 words buffered -> source_valid=0 and busy=0 next cycle; a following packet is delivered correctly.
